// File: rtl/line_drawer_if.sv
// Request/pixel bundle between the task FSM, the line drawer and the VGA adapter.
// The drawer takes the slave modport; the requesting side takes the master modport.
interface line_drawer_if;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] x1;
  logic [6:0] y1;
  logic [2:0] colour;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output start, x0, y0, x1, y1, colour,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, x0, y0, x1, y1, colour,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/line_drawer.sv
// Bresenham line drawer, all octants, one pixel per clock to the VGA adapter.
// Optional macro LINE_DRAWER_CLIP_EN suppresses vga_plot for off-screen pixels.
module line_drawer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic         clk,
  input  logic         rst_n,
  line_drawer_if.slave io_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

`ifdef LINE_DRAWER_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_cur_x, w_cur_x_nxt, r_end_x, w_end_x_nxt;
  logic [6:0]         r_cur_y, w_cur_y_nxt, r_end_y, w_end_y_nxt;
  logic [2:0]         r_colour, w_colour_nxt;
  logic signed [10:0] r_dx, w_dx_nxt, r_dy, w_dy_nxt, r_err, w_err_nxt;
  logic               r_sx_neg, w_sx_neg_nxt, r_sy_neg, w_sy_neg_nxt;
  logic               r_done, w_done_nxt;
  logic [7:0]         r_vga_x, w_vga_x_nxt;
  logic [6:0]         r_vga_y, w_vga_y_nxt;
  logic [2:0]         r_vga_colour, w_vga_colour_nxt;
  logic               r_vga_plot, w_draw_nxt;

  logic signed [10:0] w_cx, w_cy, w_ex, w_ey, w_ddx, w_ddy, w_adx, w_ady, w_e2;
  logic [7:0]         w_step_x;
  logic [6:0]         w_step_y;
  logic signed [10:0] w_step_err;
  logic               w_in_bounds, w_plot_gate;

  // 11-bit signed views of the current point and endpoint; every intermediate fits without overflow
  assign w_cx  = {3'b000, r_cur_x};
  assign w_cy  = {4'b0000, r_cur_y};
  assign w_ex  = {3'b000, r_end_x};
  assign w_ey  = {4'b0000, r_end_y};
  assign w_ddx = w_ex - w_cx;
  assign w_ddy = w_ey - w_cy;
  assign w_adx = w_ddx[10] ? -w_ddx : w_ddx;
  assign w_ady = w_ddy[10] ? -w_ddy : w_ddy;
  assign w_e2  = {r_err[9:0], 1'b0};

  assign w_in_bounds = ({24'd0, w_vga_x_nxt} < 32'(SCREEN_W)) &&
                       ({25'd0, w_vga_y_nxt} < 32'(SCREEN_H));
  assign w_plot_gate = w_in_bounds | ~CLIP_EN;

  // One Bresenham step; x and y updates may both fire and their error terms add
  always_comb begin
    w_step_x   = r_cur_x;
    w_step_y   = r_cur_y;
    w_step_err = r_err;
    if (w_e2 >= r_dy) begin
      w_step_x   = r_sx_neg ? (r_cur_x - 8'd1) : (r_cur_x + 8'd1);
      w_step_err = r_err + r_dy;
    end else begin
      w_step_x   = r_cur_x;
    end
    if (w_e2 <= r_dx) begin
      w_step_y   = r_sy_neg ? (r_cur_y - 7'd1) : (r_cur_y + 7'd1);
      w_step_err = w_step_err + r_dx;
    end else begin
      w_step_y   = r_cur_y;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_cur_x_nxt      = r_cur_x;
    w_cur_y_nxt      = r_cur_y;
    w_end_x_nxt      = r_end_x;
    w_end_y_nxt      = r_end_y;
    w_colour_nxt     = r_colour;
    w_dx_nxt         = r_dx;
    w_dy_nxt         = r_dy;
    w_err_nxt        = r_err;
    w_sx_neg_nxt     = r_sx_neg;
    w_sy_neg_nxt     = r_sy_neg;
    w_done_nxt       = r_done;
    w_vga_x_nxt      = r_vga_x;
    w_vga_y_nxt      = r_vga_y;
    w_vga_colour_nxt = r_vga_colour;
    w_draw_nxt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_bus.start) begin
          w_state_nxt  = INIT;
          w_cur_x_nxt  = io_bus.x0;
          w_cur_y_nxt  = io_bus.y0;
          w_end_x_nxt  = io_bus.x1;
          w_end_y_nxt  = io_bus.y1;
          w_colour_nxt = io_bus.colour;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      INIT: begin
        w_state_nxt      = DRAW;
        w_dx_nxt         = w_adx;
        w_dy_nxt         = -w_ady;
        w_sx_neg_nxt     = ~(w_cx < w_ex);
        w_sy_neg_nxt     = ~(w_cy < w_ey);
        w_err_nxt        = w_adx - w_ady;
        w_vga_x_nxt      = r_cur_x;
        w_vga_y_nxt      = r_cur_y;
        w_vga_colour_nxt = r_colour;
        w_draw_nxt       = 1'b1;
      end
      DRAW: begin
        if ((r_cur_x == r_end_x) && (r_cur_y == r_end_y)) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = DRAW;
          w_cur_x_nxt = w_step_x;
          w_cur_y_nxt = w_step_y;
          w_err_nxt   = w_step_err;
          w_vga_x_nxt = w_step_x;
          w_vga_y_nxt = w_step_y;
          w_draw_nxt  = 1'b1;
        end
      end
      DONE: begin
        if (!io_bus.start) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b0;
        end else begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any line in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cur_x      <= 8'd0;
      r_cur_y      <= 7'd0;
      r_end_x      <= 8'd0;
      r_end_y      <= 7'd0;
      r_colour     <= 3'd0;
      r_dx         <= 11'sd0;
      r_dy         <= 11'sd0;
      r_err        <= 11'sd0;
      r_sx_neg     <= 1'b0;
      r_sy_neg     <= 1'b0;
      r_done       <= 1'b0;
      r_vga_x      <= 8'd0;
      r_vga_y      <= 7'd0;
      r_vga_colour <= 3'd0;
      r_vga_plot   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_x      <= w_cur_x_nxt;
      r_cur_y      <= w_cur_y_nxt;
      r_end_x      <= w_end_x_nxt;
      r_end_y      <= w_end_y_nxt;
      r_colour     <= w_colour_nxt;
      r_dx         <= w_dx_nxt;
      r_dy         <= w_dy_nxt;
      r_err        <= w_err_nxt;
      r_sx_neg     <= w_sx_neg_nxt;
      r_sy_neg     <= w_sy_neg_nxt;
      r_done       <= w_done_nxt;
      r_vga_x      <= w_vga_x_nxt;
      r_vga_y      <= w_vga_y_nxt;
      r_vga_colour <= w_vga_colour_nxt;
      r_vga_plot   <= w_draw_nxt & w_plot_gate;
    end
  end

  assign io_bus.done       = r_done;
  assign io_bus.vga_x      = r_vga_x;
  assign io_bus.vga_y      = r_vga_y;
  assign io_bus.vga_colour = r_vga_colour;
  assign io_bus.vga_plot   = r_vga_plot;

endmodule

// File: tb/tb_line_drawer.sv
// Scoreboard bench for line_drawer: expected pixels are queued per line and
// popped by a negedge monitor whenever vga_plot is high.
module tb_line_drawer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  line_drawer_if bus();

  line_drawer #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

`ifdef LINE_DRAWER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  int          checks   = 0;
  int          errors   = 0;
  int          plot_cnt = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_exp;

  // pixel monitor: every plot must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.vga_plot === 1'b1) begin
      plot_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot got (%0d,%0d,c%0d) required no plot",
                 bus.vga_x, bus.vga_y, bus.vga_colour);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== mon_exp) begin
          errors++;
          $display("FAIL pixel got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                   bus.vga_x, bus.vga_y, bus.vga_colour,
                   mon_exp[17:10], mon_exp[9:3], mon_exp[2:0]);
        end
      end
    end
  end

  task automatic push_pix(input int x, input int y, input logic [2:0] c);
    logic [7:0] xx;
    logic [6:0] yy;
    xx = x[7:0];
    yy = y[6:0];
    exp_q.push_back({xx, yy, c});
  endtask

  // reference Bresenham in plain integers, clip-aware
  task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                            input logic [2:0] c);
    int dx, dy, sx, sy, err, e2, x, y;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    for (int i = 0; i < 600; i++) begin
      if (!CLIP || (x < 160 && y < 120)) push_pix(x, y, c);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // drive one request and check done timing, plot count and scoreboard drain
  task automatic run_line(input logic [7:0] x0, input logic [6:0] y0,
                          input logic [7:0] x1, input logic [6:0] y1,
                          input logic [2:0] c, input int n_draw, input int n_plots,
                          input bit scramble, input bit drop);
    int done_at;
    done_at = -1;
    @(negedge clk);
    bus.x0 = x0; bus.y0 = y0; bus.x1 = x1; bus.y1 = y1; bus.colour = c;
    bus.start = 1'b1;
    plot_cnt = 0;
    for (int cyc = 0; cyc <= n_draw + 20; cyc++) begin
      @(negedge clk);
      if (scramble && cyc == 0) begin
        bus.x0 = 8'($urandom); bus.y0 = 7'($urandom);
        bus.x1 = 8'($urandom); bus.y1 = 7'($urandom);
        bus.colour = 3'($urandom);
      end
      if (drop && cyc == 2) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        done_at = cyc;
        break;
      end
    end
    checks++;
    if (done_at != n_draw + 1) begin
      errors++;
      $display("FAIL done_timing got cycle %0d required %0d", done_at, n_draw + 1);
    end
    checks++;
    if (plot_cnt != n_plots) begin
      errors++;
      $display("FAIL plot_count got %0d required %0d", plot_cnt, n_plots);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pixels got %0d left required 0", exp_q.size());
    end
    exp_q.delete();
    if (drop) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse got done=%b one cycle later required 0", bus.done);
      end
    end
  endtask

  task automatic end_line();
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_release got %b required 0", bus.done);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.x0 = 8'd0; bus.y0 = 7'd0;
    bus.x1 = 8'd0; bus.y1 = 7'd0; bus.colour = 3'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.done, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0",
               {bus.done, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.vga_plot !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got done=%b plot=%b required 0 0", bus.done, bus.vga_plot);
    end
  endtask

  task automatic test_horizontal();
    for (int x = 0; x <= 5; x++) push_pix(x, 0, 3'b100);
    run_line(8'd0, 7'd0, 8'd5, 7'd0, 3'b100, 6, 6, 1'b1, 1'b0);
    end_line();
  endtask

  task automatic test_diagonal();
    push_pix(0, 0, 3'b011); push_pix(1, 0, 3'b011);
    push_pix(2, 1, 3'b011); push_pix(3, 1, 3'b011);
    run_line(8'd0, 7'd0, 8'd3, 7'd1, 3'b011, 4, 4, 1'b0, 1'b0);
    end_line();
    push_pix(3, 1, 3'b010); push_pix(2, 1, 3'b010);
    push_pix(1, 0, 3'b010); push_pix(0, 0, 3'b010);
    run_line(8'd3, 7'd1, 8'd0, 7'd0, 3'b010, 4, 4, 1'b0, 1'b0);
    end_line();
  endtask

  task automatic test_steep();
    model_line(20, 30, 17, 20, 3'b101);
    run_line(8'd20, 7'd30, 8'd17, 7'd20, 3'b101, 11, 11, 1'b1, 1'b0);
    end_line();
  endtask

  task automatic test_single_and_hold();
    push_pix(10, 10, 3'b111);
    run_line(8'd10, 7'd10, 8'd10, 7'd10, 3'b111, 1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.vga_plot !== 1'b0) begin
        errors++;
        $display("FAIL hold_done cycle %0d got done=%b plot=%b required 1 0",
                 i, bus.done, bus.vga_plot);
      end
    end
    end_line();
    model_line(50, 40, 44, 47, 3'b001);
    run_line(8'd50, 7'd40, 8'd44, 7'd47, 3'b001, 8, 8, 1'b0, 1'b0);
    end_line();
  endtask

  task automatic test_drop_mid();
    model_line(0, 0, 7, 3, 3'b110);
    run_line(8'd0, 7'd0, 8'd7, 7'd3, 3'b110, 8, 8, 1'b0, 1'b1);
  endtask

  task automatic test_clip();
    model_line(155, 118, 165, 118, 3'b010);
    run_line(8'd155, 7'd118, 8'd165, 7'd118, 3'b010, 11, CLIP ? 5 : 11, 1'b0, 1'b0);
    end_line();
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    model_line(0, 0, 10, 0, 3'b101);
    @(negedge clk);
    bus.x0 = 8'd0; bus.y0 = 7'd0; bus.x1 = 8'd10; bus.y1 = 7'd0; bus.colour = 3'b101;
    bus.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.vga_plot === 1'b1 && bus.vga_x === 8'd2) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reach_pixel3 got no third pixel required x=2 plot");
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.done, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot} !== 20'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h required 0",
               {bus.done, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot});
    end
    exp_q.delete();
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.vga_plot !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle got done=%b plot=%b required 0 0", bus.done, bus.vga_plot);
      end
    end
    model_line(1, 2, 4, 2, 3'b011);
    run_line(8'd1, 7'd2, 8'd4, 7'd2, 3'b011, 4, 4, 1'b0, 1'b0);
    end_line();
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_diagonal();
    test_steep();
    test_single_and_hold();
    test_drop_mid();
    test_clip();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
